// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port pixel RAM between VGA scan-out,
// a full-framebuffer clear engine and an external pixel writer.
module vga_fb_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              clk_25,
  input  logic              reset,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              in_display_area,
  output logic [2:0]        pixel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [2:0]        ram_wdata,
  input  logic [2:0]        ram_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              wr_ready,
  input  logic              clear_start,
  input  logic [2:0]        clear_color,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int FB_SIZE = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_SIZE - 1);
  localparam logic [ADDR_W:0] SIZE = (ADDR_W + 1)'(FB_SIZE);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [2:0]        col_q;
  logic              busy_q;
  logic              done_q;

  logic              disp_q1;
  logic              slot_q1;
  logic [2:0]        pixel_q;

  logic              slot;
  logic [9:0]        fb_x;
  logic [9:0]        fb_y;
  logic [ADDR_W-1:0] scan_addr;
  logic              wr_in_range;

  // One fetch per framebuffer pixel: the first screen column of each block.
  assign slot = in_display_area
             && (counter_x[SCALE_LOG2-1:0] == '0);

  assign fb_x = counter_x >> SCALE_LOG2;
  assign fb_y = counter_y >> SCALE_LOG2;

  assign scan_addr = ADDR_W'(fb_y) * ADDR_W'(FB_W)
                   + ADDR_W'(fb_x);

  assign wr_in_range = ({1'b0, wr_addr} < SIZE);

  // Port grant: scan-out, then clear engine, then writer.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ready  = 1'b0;
    if (!reset) begin
      if (slot) begin
        ram_addr = scan_addr;
      end else if (state_q == S_CLEAR) begin
        ram_we    = 1'b1;
        ram_addr  = cnt_q;
        ram_wdata = col_q;
      end else begin
        wr_ready = 1'b1;
        if (wr_req && wr_in_range) begin
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
      end
    end
  end

  // Clear engine: walks every address once, stalling on display slots.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_start) begin
            state_q <= S_CLEAR;
            col_q   <= clear_color;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (!slot) begin
            if (cnt_q == LAST) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pixel pipeline: latch RAM data the cycle after a fetch, hold across
  // the block, blank outside the visible area.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      disp_q1 <= 1'b0;
      slot_q1 <= 1'b0;
      pixel_q <= '0;
    end else begin
      disp_q1 <= in_display_area;
      slot_q1 <= slot;
      if (slot_q1) begin
        pixel_q <= ram_rdata;
      end else if (!disp_q1) begin
        pixel_q <= '0;
      end
    end
  end

  assign pixel      = pixel_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule
